btn_led_sequencer: RTL

BTN_LED_SEQUENCER -- requirements
Module: btn_led_sequencer

---
 rtl/btn_led_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/btn_led_sequencer.sv
// Push-button driven LED sequencer: synchronises and debounces an active-low button,
// and each accepted press advances the LED pattern according to the selected mode.
module btn_led_sequencer #(
  parameter int N_LEDS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              btn_external_connection_export,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] leds_external_connection_export,
  output logic              step_pulse,
  output logic [7:0]        press_count
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_LEDS-1:0] LED_INIT = {{(N_LEDS-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_WALK   = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_COUNT  = 2'b10;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic              sync1_r, sync2_r;
  logic              deb_r, deb_prev_r;
  logic [CW-1:0]     cnt_r;
  logic [1:0]        mode_r;
  dir_t              dir_r;
  logic [N_LEDS-1:0] leds_r;
  logic              step_r;
  logic [7:0]        count_r;

  logic              deb_s;
  logic [CW-1:0]     cnt_s;
  logic              press_s;
  logic [N_LEDS-1:0] leds_s;
  dir_t              dir_s;

  // Debounce: the accepted level only follows the synchronised input once it has differed long enough
  always_comb begin
    deb_s = deb_r;
    cnt_s = cnt_r;
    if (sync2_r == deb_r) begin
      cnt_s = '0;
    end else if (cnt_r == CNT_MAX) begin
      deb_s = sync2_r;
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CW'(1);
    end
  end

  // Press is a debounced falling edge; a release produces nothing
  always_comb begin
    press_s = deb_prev_r & ~deb_r;
  end

  // Next LED pattern and bounce direction; a mode change reinitialises ahead of any step
  always_comb begin
    leds_s = leds_r;
    dir_s  = dir_r;
    if (mode != mode_r) begin
      case (mode)
        MODE_WALK, MODE_BOUNCE: begin
          leds_s = LED_INIT;
          dir_s  = DIR_UP;
        end
        MODE_COUNT: begin
          leds_s = '0;
          dir_s  = DIR_UP;
        end
        default: begin
          leds_s = leds_r;
          dir_s  = dir_r;
        end
      endcase
    end else if (press_s) begin
      case (mode_r)
        MODE_WALK: begin
          leds_s = {leds_r[N_LEDS-2:0], leds_r[N_LEDS-1]};
        end
        MODE_BOUNCE: begin
          if (dir_r == DIR_UP) begin
            if (leds_r[N_LEDS-1]) begin
              leds_s = leds_r >> 1;
              dir_s  = DIR_DOWN;
            end else begin
              leds_s = leds_r << 1;
            end
          end else begin
            if (leds_r[0]) begin
              leds_s = leds_r << 1;
              dir_s  = DIR_UP;
            end else begin
              leds_s = leds_r >> 1;
            end
          end
        end
        MODE_COUNT: begin
          leds_s = leds_r + N_LEDS'(1);
        end
        default: begin
          leds_s = leds_r;
        end
      endcase
    end else begin
      leds_s = leds_r;
      dir_s  = dir_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      deb_r      <= 1'b1;
      deb_prev_r <= 1'b1;
      cnt_r      <= '0;
      mode_r     <= MODE_WALK;
      dir_r      <= DIR_UP;
      leds_r     <= LED_INIT;
      step_r     <= 1'b0;
      count_r    <= 8'd0;
    end else begin
      sync1_r    <= btn_external_connection_export;
      sync2_r    <= sync1_r;
      deb_r      <= deb_s;
      deb_prev_r <= deb_r;
      cnt_r      <= cnt_s;
      mode_r     <= mode;
      dir_r      <= dir_s;
      leds_r     <= leds_s;
      step_r     <= press_s;
      count_r    <= press_s ? (count_r + 8'd1) : count_r;
    end
  end

  assign leds_external_connection_export = leds_r;
  assign step_pulse                      = step_r;
  assign press_count                     = count_r;

endmodule
